// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment result display:
//   - active-low segment glyphs, bit order g..a (bit 0 = segment a)
//   - digit-slot index type used by the scan logic
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_HUND = 2'd2,
        DIG_SIGN = 2'd3
    } dig_t;

endpackage

// File: rtl/seg7_result_display_bcd_to_seg.sv
// bcd_to_seg
// Combinational BCD nibble to active-low seven-segment glyph.
//   i_nibble : 4-bit BCD digit; values above 9 render as 'E'
//   i_blank  : force all segments off
//   o_seg    : glyph, active low, bit 0 = segment a
module bcd_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_ERR;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_nibble)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_ERR;
            endcase
        end
    end

endmodule

// File: rtl/seg7_result_display.sv
// seg7_result_display
// Captures a 3-digit BCD result with sign and overflow flags and scans it
// onto a 4-digit common-anode seven-segment display.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bcd_in : BCD result, [11:8] hundreds, [7:4] tens, [3:0] ones
//   neg_in : result negative
//   ovf_in : overflow flag; blinks the display while captured high
//   load   : single-cycle capture strobe
//   seg    : segments, active low, seg[0]=a .. seg[6]=g
//   dp     : decimal point, active low, always off
//   an     : anodes, active low, an[0]=ones .. an[3]=sign
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        neg_in,
    input  logic        ovf_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] r_presc;
    dig_t          r_idx;
    logic [11:0]   r_bcd;
    logic          r_neg;
    logic          r_ovf;
    logic [BW-1:0] r_bcnt;
    logic          r_blink_off;
    logic [6:0]    r_stage_seg;
    logic [3:0]    r_stage_an;
    logic          r_stage_vld;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_tick;
    logic [3:0]    w_nibble;
    logic          w_blank;
    logic          w_hund_zero;
    logic          w_tens_zero;
    logic [6:0]    w_dec_seg;
    logic [6:0]    w_glyph;
    logic [3:0]    w_an;

    assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= DIG_ONES;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= dig_t'(2'(r_idx + 2'd1));
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_bcd <= bcd_in;
            r_neg <= neg_in;
            r_ovf <= ovf_in;
        end
    end

    // Clearing overflow restarts the blink in the on phase; a load that keeps
    // overflow set lets the running blink continue undisturbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (load && !ovf_in) begin
            r_bcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (w_tick && r_ovf) begin
            if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                r_bcnt      <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    // Illegal nibbles are non-zero, so they keep the lower digits visible.
    assign w_hund_zero = (r_bcd[11:8] == 4'd0);
    assign w_tens_zero = w_hund_zero && (r_bcd[7:4] == 4'd0);

    always_comb begin
        w_nibble = r_bcd[3:0];
        w_blank  = 1'b0;
        case (r_idx)
            DIG_ONES: begin
                w_nibble = r_bcd[3:0];
                w_blank  = 1'b0;
            end
            DIG_TENS: begin
                w_nibble = r_bcd[7:4];
                w_blank  = w_tens_zero;
            end
            DIG_HUND: begin
                w_nibble = r_bcd[11:8];
                w_blank  = w_hund_zero;
            end
            default: begin
                w_nibble = 4'd0;
                w_blank  = 1'b1;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_dec_seg)
    );

    assign w_glyph = (r_idx == DIG_SIGN) ? (r_neg ? SEG_MINUS : SEG_BLANK) : w_dec_seg;
    assign w_an    = r_blink_off ? 4'b1111 : ~(4'b0001 << r_idx);

    // The slot content is sampled on the tick edge itself, so a load on that
    // same edge shows up one slot later; the pins follow one cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_seg <= SEG_BLANK;
            r_stage_an  <= 4'b1111;
            r_stage_vld <= 1'b0;
            r_seg       <= SEG_BLANK;
            r_an        <= 4'b1111;
        end else begin
            r_stage_vld <= w_tick;
            if (w_tick) begin
                r_stage_seg <= w_glyph;
                r_stage_an  <= w_an;
            end
            if (r_stage_vld) begin
                r_seg <= r_stage_seg;
                r_an  <= r_stage_an;
            end
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_result_display.sv
module tb_seg7_result_display;

    localparam int RDIV = 4;
    localparam int BDIV = 2;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        neg_in;
    logic        ovf_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_result_display #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bcd_in (bcd_in),
        .neg_in (neg_in),
        .ovf_in (ovf_in),
        .load   (load),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph for one decimal value, active low g..a.
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 9) return 7'b0000110;
        return tbl[v];
    endfunction

    // What a digit position should show, from the display rules.
    function automatic logic [6:0] digit_glyph(input logic [11:0] v, input logic neg, input int pos);
        int h, t, o;
        h = int'(v[11:8]);
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        case (pos)
            0:       return glyph(o);
            1:       return (h == 0 && t == 0) ? 7'b1111111 : glyph(t);
            2:       return (h == 0) ? 7'b1111111 : glyph(h);
            default: return neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    // Reference model: cycle counting from reset, slot number = tick count
    // mod 4, blink phase = (overflow ticks / BDIV) mod 2.
    int          m_cnt, m_slot, m_ovf_ticks;
    logic [11:0] m_val;
    logic        m_neg, m_ovf;
    logic [6:0]  m_pend_seg, exp_seg;
    logic [3:0]  m_pend_an, exp_an;
    logic        m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_slot = 0; m_ovf_ticks = 0;
            m_val = '0; m_neg = 0; m_ovf = 0;
            m_pend = 0; m_pend_seg = 7'h7F; m_pend_an = 4'hF;
            exp_seg = 7'h7F; exp_an = 4'hF;
        end else begin
            if (m_pend) begin
                exp_seg = m_pend_seg;
                exp_an  = m_pend_an;
            end
            m_pend = 0;
            if (m_cnt == RDIV - 1) begin
                m_pend_seg = digit_glyph(m_val, m_neg, m_slot);
                if (m_ovf && ((m_ovf_ticks / BDIV) % 2 == 1)) m_pend_an = 4'hF;
                else m_pend_an = ~(4'b0001 << m_slot);
                m_pend = 1;
                m_slot = (m_slot + 1) % 4;
                if (m_ovf) m_ovf_ticks++;
            end
            m_cnt = (m_cnt + 1) % RDIV;
            if (load) begin
                m_val = bcd_in;
                m_neg = neg_in;
                if (!ovf_in) m_ovf_ticks = 0;
                m_ovf = ovf_in;
            end
        end
    end

    // Continuous comparison of the pins against the model.
    always @(negedge clk) begin
        check("pins_vs_model", {20'd0, an, seg, dp}, {20'd0, exp_an, exp_seg, 1'b1});
    end

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        logic [6:0]  exp [4];
    } vec_t;

    task automatic do_load(input logic [11:0] v, input logic n, input logic o);
        bcd_in = v; neg_in = n; ovf_in = o; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        vec_t vecs [6];
        logic [6:0] got [4];
        logic       seen [4];
        logic       off [8];
        int         n_off, w;
        logic [11:0] rv;

        vecs[0] = '{12'h123, 1'b0, '{7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111}};
        vecs[1] = '{12'h007, 1'b1, '{7'b1111000, 7'b1111111, 7'b1111111, 7'b0111111}};
        vecs[2] = '{12'h0A5, 1'b0, '{7'b0010010, 7'b0000110, 7'b1111111, 7'b1111111}};
        vecs[3] = '{12'h000, 1'b0, '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111}};
        vecs[4] = '{12'hF0C, 1'b1, '{7'b0000110, 7'b1000000, 7'b0000110, 7'b0111111}};
        vecs[5] = '{12'h090, 1'b0, '{7'b1000000, 7'b0010000, 7'b1111111, 7'b1111111}};

        rst_n = 1'b0; bcd_in = '0; neg_in = 0; ovf_in = 0; load = 0;
        repeat (10) begin
            @(negedge clk);
            check("reset_an", {28'd0, an}, 32'hF);
            check("reset_seg", {25'd0, seg}, {25'd0, 7'h7F});
            check("reset_dp", {31'd0, dp}, 32'd1);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("pre_first_tick_an", {28'd0, an}, 32'hF);
        end
        @(negedge clk);
        check("first_slot_an", {28'd0, an}, 32'b1110);
        check("first_slot_seg", {25'd0, seg}, {25'd0, 7'b1000000});

        // Table-driven glyph checks over one full scan.
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].bcd, vecs[i].neg, 1'b0);
            repeat (2 * 4 * RDIV) @(negedge clk);
            for (int d = 0; d < 4; d++) seen[d] = 0;
            repeat (4 * RDIV) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++)
                    if (an == ~(4'b0001 << d)) begin
                        got[d] = seg; seen[d] = 1;
                    end
            end
            for (int d = 0; d < 4; d++) begin
                check($sformatf("vec%0d_digit%0d_seen", i, d), {31'd0, seen[d]}, 32'd1);
                check($sformatf("vec%0d_digit%0d_seg", i, d), {25'd0, got[d]}, {25'd0, vecs[i].exp[d]});
            end
        end

        // Overflow blink: runs of two slots off, two on.
        do_load(12'h123, 1'b0, 1'b1);
        repeat (2 * RDIV) @(negedge clk);
        n_off = 0;
        for (int s = 0; s < 8; s++) begin
            off[s] = (an == 4'hF);
            if (off[s]) n_off++;
            repeat (RDIV) @(negedge clk);
        end
        check("blink_off_count", n_off, 4);
        w = 0;
        for (int s = 0; s < 6; s++)
            if (off[s] == off[s+1] && off[s+1] == off[s+2]) w++;
        check("blink_no_run_of_3", w, 0);
        do_load(12'h123, 1'b0, 1'b0);
        repeat (2 * RDIV) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check("blink_stopped", {31'd0, (an == 4'hF)}, 32'd0);
            repeat (RDIV) @(negedge clk);
        end

        // Load on the same edge as a scan tick that stages the ones digit.
        do_load(12'h000, 1'b0, 1'b0);
        w = 0;
        while (!(m_cnt == RDIV - 1 && m_slot == 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("align_tick_timeout", {31'd0, (w < 100)}, 32'd1);
        do_load(12'h999, 1'b0, 1'b0);
        @(negedge clk);
        check("same_edge_old_an", {28'd0, an}, 32'b1110);
        check("same_edge_old_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        repeat (RDIV) @(negedge clk);
        check("same_edge_new_an", {28'd0, an}, 32'b1101);
        check("same_edge_new_seg", {25'd0, seg}, {25'd0, 7'b0010000});

        // Randomised loads, checked continuously against the model.
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            for (int b = 0; b < 3; b++)
                rv[b*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                           : (($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9)));
            do_load(rv, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a slot.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midslot_reset_an", {28'd0, an}, 32'hF);
        check("midslot_reset_seg", {25'd0, seg}, {25'd0, 7'h7F});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_an", {28'd0, an}, 32'b1110);
        check("post_reset_seg", {25'd0, seg}, {25'd0, 7'b1000000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_result_display.md
Name: seg7_result_display

Overview:
- Downstream display stage for the calculator datapath.
- Captures the 12-bit BCD result, negative flag and overflow flag on a load strobe.
- Time-multiplexes them onto a 4-digit common-anode seven-segment display: three magnitude digits plus a sign digit.
- Provides leading-zero blanking, an error glyph for illegal BCD nibbles, and display blinking while overflow is latched.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (scan tick period); legal range is 2 or more.
- BLINK_DIV, 256: scan ticks per blink half-period while overflow is latched; legal range is 1 or more.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bcd_in  input  12  BCD result; [11:8] hundreds, [7:4] tens, [3:0] ones
- neg_in  input  1  result is negative
- ovf_in  input  1  arithmetic overflow flag
- load  input  1  single-cycle capture strobe for bcd_in, neg_in and ovf_in
- seg  output  7  segments, active low; seg[0]=a through seg[6]=g
- dp  output  1  decimal point, active low; always 1 (off) outside reset
- an  output  4  digit anodes, active low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=sign

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low.
  - While rst_n=0: an=4'b1111, seg=7'b1111111, dp=1.
  - Also cleared: captured value, captured neg/ovf, prescaler, digit index, blink counter, blink phase.
  - First scan tick occurs REFRESH_DIV cycles after rst_n deasserts.
- Capture: on a clk edge with load=1, bcd_in/neg_in/ovf_in are registered.
  - The new value appears at the next digit-output update after capture. The scan is not restarted.
  - With no load, the held value persists indefinitely.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps.
  - The wrap cycle is the scan tick.
  - On each tick the digit index advances 0 to 1 to 2 to 3 and wraps back to 0.
- Outputs are registered: seg/an change one cycle after the index advance.
  - Exactly one anode is low at a time, except during blink-off.
- Digit content:
  - Digit 0 (ones) is never blanked.
  - Digit 1 (tens) is blank if hundreds=0 and tens=0.
  - Digit 2 (hundreds) is blank if hundreds=0.
  - Digit 3 (sign) shows '-' (seg=7'b0111111) if neg is captured, else blank (7'b1111111).
- Illegal nibble (value above 9) shows 'E' (7'b0000110).
  - A non-zero illegal nibble counts as non-zero for blanking purposes.
- Blink:
  - While captured ovf=1, the blink counter counts scan ticks.
  - Every BLINK_DIV ticks the blink phase toggles.
  - During the off phase an=4'b1111, while the scan continues.
  - When a load clears ovf, blink counter and phase reset to 0 (on phase) on the same edge.
- Simultaneous load and scan tick: both take effect on the same edge. The displayed digit uses the newly captured value at the following output update.
- Reset mid-scan: everything returns to reset values immediately (asynchronously). No partial digit survives.

Decomposition:
- Shared package seg7_pkg holds:
  - the segment glyph constants, active low, g..a order:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - BLANK=1111111, MINUS=0111111, ERR=0000110
  - the digit-index typedef with values DIG_ONES, DIG_TENS, DIG_HUND, DIG_SIGN.
- One combinational sub-module, bcd_to_seg: 4-bit nibble plus blank flag in, 7-bit glyph out.
- Prescaler, scan index, blink logic and capture registers live in the top.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
- Reset, then hold rst_n=0 for 10 cycles -> an=1111, seg=1111111, dp=1 throughout. The first anode goes low 5 cycles after release, showing an=1110 with ones glyph 1000000.
- Load bcd=12'h123, neg=0 -> over one scan period the bench sees:
  - an=1110 with seg=0110000 (3)
  - an=1101 with seg=0100100 (2)
  - an=1011 with seg=1111001 (1)
  - an=0111 with seg=1111111
- Load bcd=12'h007, neg=1 -> ones=1111000, tens blank, hundreds blank, sign=0111111.
- Load bcd=12'h0A5 -> hundreds blank, tens=0000110 (E), ones=0010010.
- Load with ovf=1 -> an=1111 for 2 consecutive scan ticks, then normal for 2 ticks, repeating. A subsequent load with ovf=0 stops blinking on the next tick.
- Assert load in the same cycle as a scan tick with bcd=12'h999 (previously 12'h000) -> that slot shows the old value and the following slot shows 9. Asserting rst_n=0 mid-slot forces an=1111 in the same cycle.
